// File: rtl/safe_cracker_pkg.sv
// Shared definitions for the safe datapath and the automatic combination finder.
// Code and hint widths are common to the lock and the cracker.
package safe_pkg;
    localparam int CODE_W = 10;
    localparam int HINT_W = $clog2(CODE_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        BASE,
        PROBE,
        SUBMIT,
        DONE,
        FAIL
    } state_e;
endpackage

// File: rtl/safe_cracker_if.sv
// User-side connection between the cracker and the lock: probe codes out,
// hint/unlocked back, plus the start/status handshake.
interface safe_cracker_if #(
    parameter int WIDTH = safe_pkg::CODE_W
);
    localparam int HW = $clog2(WIDTH + 1);

    logic             start;
    logic [HW-1:0]    hint;
    logic             unlocked;
    logic [WIDTH-1:0] guess;
    logic             enter;
    logic             busy;
    logic             done;
    logic             fail;
    logic [WIDTH-1:0] found;

    modport master (
        input  start, hint, unlocked,
        output guess, enter, busy, done, fail, found
    );

    modport slave (
        output start, hint, unlocked,
        input  guess, enter, busy, done, fail, found
    );
endinterface

// File: rtl/safe_cracker_probe_timer.sv
// Settle timer shared by every cracker phase: load starts a phase of SETTLE
// cycles and last flags the final cycle, where the lock's response is sampled.
module probe_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(SETTLE - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);
endmodule

// File: rtl/safe_cracker.sv
// Recovers the lock password one bit at a time from mismatch-count hints,
// then submits it with a single enter pulse and reports done or fail.
module safe_cracker
    import safe_pkg::*;
#(
    parameter int WIDTH  = CODE_W,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           reset,
    safe_cracker_if.master bus
);
    localparam int HW = $clog2(WIDTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [HW-1:0]    h0_q, h0_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic             enter_q, enter_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             timer_load;
    logic             timer_last;
    logic [HW:0]      hint_x, h0_x;

    probe_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .last (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        h0_d       = h0_q;
        guess_d    = guess_q;
        found_d    = found_q;
        enter_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        // One extra bit so h0-1 with h0==0 cannot wrap onto a real hint value.
        hint_x     = {1'b0, bus.hint};
        h0_x       = {1'b0, h0_q};

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (bus.start) begin
                    state_d    = BASE;
                    guess_d    = '0;
                    found_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            BASE: begin
                if (timer_last) begin
                    h0_d       = bus.hint;
                    bit_d      = '0;
                    guess_d    = WIDTH'(1);
                    state_d    = PROBE;
                    timer_load = 1'b1;
                end
            end
            PROBE: begin
                if (timer_last) begin
                    if (hint_x + {{HW{1'b0}}, 1'b1} == h0_x) begin
                        found_d[bit_q] = 1'b1;
                    end else if (hint_x == h0_x + {{HW{1'b0}}, 1'b1}) begin
                        found_d[bit_q] = 1'b0;
                    end else begin
                        state_d = FAIL;
                        busy_d  = 1'b0;
                        fail_d  = 1'b1;
                    end
                    if (state_d == PROBE) begin
                        timer_load = 1'b1;
                        if (bit_q == BW'(WIDTH - 1)) begin
                            state_d = SUBMIT;
                            guess_d = found_d;
                            enter_d = 1'b1;
                        end else begin
                            bit_d          = bit_q + 1'b1;
                            guess_d        = '0;
                            guess_d[bit_d] = 1'b1;
                        end
                    end
                end
            end
            SUBMIT: begin
                if (timer_last) begin
                    busy_d = 1'b0;
                    if (bus.unlocked) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            h0_q    <= '0;
            guess_q <= '0;
            found_q <= '0;
            enter_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            h0_q    <= h0_d;
            guess_q <= guess_d;
            found_q <= found_d;
            enter_q <= enter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.guess = guess_q;
    assign bus.found = found_q;
    assign bus.enter = enter_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.fail  = fail_q;
endmodule

// File: tb/tb_safe_cracker.sv
// Bench for safe_cracker: behavioural lock models drive hint/unlocked, and a
// scoreboard holds the expected outcome of each crack until done/fail rises.
module tb_safe_cracker;
    import safe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    safe_cracker_if #(.WIDTH(CODE_W)) bus_a ();
    safe_cracker_if #(.WIDTH(CODE_W)) bus_b ();

    safe_cracker #(.WIDTH(CODE_W), .SETTLE(2)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a.master)
    );

    safe_cracker #(.WIDTH(CODE_W), .SETTLE(1)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b.master)
    );

    // Lock models
    logic [CODE_W-1:0] pw_a = '0, pw_b = '0;
    logic              force_en = 1'b0;
    logic [3:0]        force_bit = '0;
    logic [HINT_W-1:0] force_val = '0;
    logic              hold_locked = 1'b0;
    logic              opened_a, opened_b;

    always @(posedge clk) begin
        if (reset || bus_a.start) opened_a <= 1'b0;
        else if (bus_a.enter && bus_a.guess == pw_a && !hold_locked) opened_a <= 1'b1;
        if (reset || bus_b.start) opened_b <= 1'b0;
        else if (bus_b.enter && bus_b.guess == pw_b) opened_b <= 1'b1;
    end

    always_comb begin
        bus_a.hint = HINT_W'($countones(bus_a.guess ^ pw_a));
        if (force_en && bus_a.guess == (CODE_W'(1) << force_bit)) bus_a.hint = force_val;
        bus_a.unlocked = !hold_locked && (opened_a || (bus_a.enter && bus_a.guess == pw_a));
        bus_b.hint     = HINT_W'($countones(bus_b.guess ^ pw_b));
        bus_b.unlocked = opened_b || (bus_b.enter && bus_b.guess == pw_b);
    end

    typedef struct {
        string             tag;
        logic [CODE_W-1:0] found;
        logic              done;
        int                cyc;
        int                n_enter;
        int                enter_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one start pulse; t is the edge at which start is sampled.
    task automatic kick(input int d, input string tag, input logic [CODE_W-1:0] pw,
                        input logic push, input logic [CODE_W-1:0] exp_found,
                        input logic exp_done, input int lat, input int n_enter,
                        input int enter_lat, output int t);
        exp_t e;
        @(negedge clk);
        if (d == 0) pw_a = pw; else pw_b = pw;
        t           = cyc + 1;
        e.tag       = tag;
        e.found     = exp_found;
        e.done      = exp_done;
        e.cyc       = t + lat;
        e.n_enter   = n_enter;
        e.enter_cyc = t + enter_lat;
        if (push) sb_q.push_back(e);
        if (d == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check({tag, "_busy_rise"}, (d == 0) ? bus_a.busy : bus_b.busy, 1);
    endtask

    task automatic wait_result(input int d);
        int                n_ent = 0;
        int                ecyc  = -1;
        bit                got   = 1'b0;
        logic              dn, fl, bs, en;
        logic [CODE_W-1:0] fd;
        exp_t              e;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            dn = (d == 0) ? bus_a.done  : bus_b.done;
            fl = (d == 0) ? bus_a.fail  : bus_b.fail;
            bs = (d == 0) ? bus_a.busy  : bus_b.busy;
            en = (d == 0) ? bus_a.enter : bus_b.enter;
            fd = (d == 0) ? bus_a.found : bus_b.found;
            if (en) begin
                n_ent++;
                ecyc = cyc + 1;
            end
            if (dn || fl) got = 1'b1;
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({e.tag, "_timeout"}, 0, 1);
            return;
        end
        check({e.tag, "_done"},    dn, e.done);
        check({e.tag, "_fail"},    fl, !e.done);
        check({e.tag, "_busy"},    bs, 0);
        check({e.tag, "_found"},   fd, e.found);
        check({e.tag, "_cycle"},   cyc + 1, e.cyc);
        check({e.tag, "_enters"},  n_ent, e.n_enter);
        if (e.n_enter > 0) check({e.tag, "_enter_cyc"}, ecyc, e.enter_cyc);
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_guess", bus_a.guess, 0);
        check("rst_enter", bus_a.enter, 0);
        check("rst_busy",  bus_a.busy,  0);
        check("rst_done",  bus_a.done,  0);
        check("rst_fail",  bus_a.fail,  0);
        check("rst_found", bus_a.found, 0);
        check("rst_b_busy", bus_b.busy, 0);
        reset = 1'b0;

        kick(0, "pw0", 10'h000, 1, 10'h000, 1, 25, 1, 23, t);
        wait_result(0);
        kick(0, "pw2a5", 10'h2A5, 1, 10'h2A5, 1, 25, 1, 23, t);
        wait_result(0);
        kick(1, "pw3ff_s1", 10'h3FF, 1, 10'h3FF, 1, 13, 1, 12, t);
        wait_result(1);

        // Bad hint on bit 3: bits 0..2 of 2A5 already recovered, no submit.
        force_en  = 1'b1;
        force_bit = 4'd3;
        force_val = HINT_W'(7);
        kick(0, "badhint", 10'h2A5, 1, 10'h005, 0, 11, 0, 0, t);
        wait_result(0);
        force_en = 1'b0;
        kick(0, "rerun", 10'h2A5, 1, 10'h2A5, 1, 25, 1, 23, t);
        wait_result(0);

        hold_locked = 1'b1;
        kick(0, "locked", 10'h1C3, 1, 10'h1C3, 0, 25, 1, 23, t);
        wait_result(0);
        hold_locked = 1'b0;

        kick(0, "intf", 10'h155, 1, 10'h155, 1, 25, 1, 23, t);
        while (cyc < t + 6) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check("intf_busy_hold", bus_a.busy, 1);
        wait_result(0);

        kick(0, "midrst", 10'h0F0, 0, 10'h000, 0, 0, 0, 0, t);
        while (cyc < t + 11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_guess", bus_a.guess, 0);
        check("midrst_enter", bus_a.enter, 0);
        check("midrst_busy",  bus_a.busy,  0);
        check("midrst_done",  bus_a.done,  0);
        check("midrst_fail",  bus_a.fail,  0);
        check("midrst_found", bus_a.found, 0);
        check("midrst_state", dut_a.state_q, IDLE);
        repeat (3) @(negedge clk);
        check("midrst_idle_busy",  bus_a.busy,  0);
        check("midrst_idle_guess", bus_a.guess, 0);

        kick(0, "fresh", 10'h0F0, 1, 10'h0F0, 1, 25, 1, 23, t);
        wait_result(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
